// File: rtl/kernel_tap_sched.sv
// rtl/kernel_tap_sched.sv - round-robin scheduler streaming 25 kernel taps from a shared weight table
module kernel_tap_sched #(
   parameter int NTAPS = 25,
   parameter int IDXW  = 5,
   parameter int DW    = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req,
   output logic [1:0]      grant,
   output logic            busy,
   output logic [IDXW-1:0] tbl_indx,
   input  logic [DW-1:0]   tbl_tv,
   output logic            tap_valid,
   input  logic            tap_ready,
   output logic [DW-1:0]   tap_data,
   output logic [IDXW-1:0] tap_idx,
   output logic            tap_last,
   output logic            tap_lane,
   output logic            done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_STREAM,
      S_DONE
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NTAPS - 1);
   localparam logic [IDXW-1:0] FIRST_CNT = IDXW'((NTAPS > 1) ? 1 : 0);

   state_t          state;
   state_t          state_next;
   logic [IDXW-1:0] cnt;
   logic            ptr;
   logic            sel_lane;
   logic            handshake;

   // Contention goes to the pointer lane; otherwise the single requester wins.
   assign sel_lane  = (&req) ? ptr : req[1];
   assign handshake = tap_valid & tap_ready;

   always_comb begin
      state_next = state;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      tbl_indx   = '0;
      case (state)
         S_IDLE: begin
            if (|req) state_next = S_GRANT;
         end
         S_GRANT: begin
            state_next = S_STREAM;
         end
         S_STREAM: begin
            tbl_indx = cnt;
            if (handshake && tap_last) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ptr       <= 1'b0;
         grant     <= 2'b00;
         tap_lane  <= 1'b0;
         tap_valid <= 1'b0;
         tap_data  <= '0;
         tap_idx   <= '0;
         tap_last  <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: begin
               if (|req) begin
                  grant    <= sel_lane ? 2'b10 : 2'b01;
                  tap_lane <= sel_lane;
                  cnt      <= '0;
               end
            end
            S_GRANT: begin
               tap_data  <= tbl_tv;
               tap_idx   <= '0;
               tap_last  <= (NTAPS == 1);
               tap_valid <= 1'b1;
               cnt       <= FIRST_CNT;
            end
            S_STREAM: begin
               if (handshake) begin
                  if (!tap_last) begin
                     tap_data <= tbl_tv;
                     tap_idx  <= cnt;
                     tap_last <= (cnt == LAST_IDX);
                     // Saturate so the table index stays in range while the last tap waits.
                     cnt      <= (cnt == LAST_IDX) ? cnt : cnt + 1'b1;
                  end else begin
                     tap_valid <= 1'b0;
                     tap_last  <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               grant <= 2'b00;
               ptr   <= ~tap_lane;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_kernel_tap_sched.sv
// tb/tb_kernel_tap_sched.sv - randomized model-checked bench with directed literal pins
module tb_kernel_tap_sched;
   localparam int NTAPS = 25;
   localparam int IDXW  = 5;
   localparam int DW    = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req;
   logic [1:0]      grant;
   logic            busy;
   logic [IDXW-1:0] tbl_indx;
   logic [DW-1:0]   tbl_tv;
   logic            tap_valid;
   logic            tap_ready;
   logic [DW-1:0]   tap_data;
   logic [IDXW-1:0] tap_idx;
   logic            tap_last;
   logic            tap_lane;
   logic            done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   kernel_tap_sched #(.NTAPS(NTAPS), .IDXW(IDXW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy),
      .tbl_indx(tbl_indx), .tbl_tv(tbl_tv), .tap_valid(tap_valid),
      .tap_ready(tap_ready), .tap_data(tap_data), .tap_idx(tap_idx),
      .tap_last(tap_last), .tap_lane(tap_lane), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] w(int i);
      case (i)
         0:  return 16'h3330;
         2:  return 16'h38F0;
         6:  return 16'h38F0;
         7:  return 16'h35C0;
         24: return 16'h3980;
         default: begin
            if (i >= 0 && i < NTAPS) return 16'h3400 + 16'(i * 17);
            return 16'hDEAD;
         end
      endcase
   endfunction

   always_comb tbl_tv = w(int'(tbl_indx));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Burst model: m_tap = -1 while granted before the first tap, 0..NTAPS-1 the tap offered,
   // NTAPS for the completion cycle.
   int m_busy = 0, m_lane = 0, m_ptr = 0, m_tap = -1;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy = 0; m_lane = 0; m_ptr = 0; m_tap = -1;
      end else if (m_busy == 0) begin
         if (req != 2'b00) begin
            m_busy = 1;
            m_lane = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
            m_tap  = -1;
         end
      end else if (m_tap == NTAPS) begin
         m_busy = 0;
         m_ptr  = 1 - m_lane;
      end else if (m_tap == -1) begin
         m_tap = 0;
      end else if (tap_ready) begin
         m_tap++;
      end
      #2;
      begin
         bit v;
         v = (m_busy == 1) && (m_tap >= 0) && (m_tap < NTAPS);
         chk("model_grant", grant, m_busy ? (m_lane ? 2'b10 : 2'b01) : 2'b00);
         chk("model_busy", busy, m_busy[0]);
         chk("model_done", done, (m_busy == 1) && (m_tap == NTAPS));
         chk("model_valid", tap_valid, v);
         chk("model_lane", tap_lane, m_lane[0]);
         if (v) begin
            chk("model_idx", tap_idx, m_tap);
            chk("model_data", tap_data, w(m_tap));
            chk("model_last", tap_last, m_tap == NTAPS - 1);
            if (m_tap < NTAPS - 1) chk("model_tbl_indx", tbl_indx, m_tap + 1);
            else chk("model_tbl_range", tbl_indx <= NTAPS - 1, 1);
         end else begin
            chk("model_last_idle", tap_last, 1'b0);
            chk("model_tbl_zero", tbl_indx, 0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic wait_idx(input int k);
      int t;
      for (t = 0; t < 200; t++) begin
         if (tap_valid && tap_idx == k) break;
         step(1);
      end
      if (t == 200) chk("timeout_idx", 0, 1);
   endtask

   task automatic wait_done();
      int t;
      for (t = 0; t < 200; t++) begin
         if (done) break;
         step(1);
      end
      if (t == 200) chk("timeout_done", 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [1:0] fair_exp [4];
      int g_cyc;
      fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
      rst = 1'b1; req = 2'b00; tap_ready = 1'b0;
      step(3);
      chk("rst_grant", grant, 2'b00);
      chk("rst_valid", tap_valid, 1'b0);
      chk("rst_data", tap_data, 16'h0);
      chk("rst_idx", tap_idx, 0);
      chk("rst_done_busy", {done, busy, tap_last, tap_lane}, 4'b0000);
      rst = 1'b0;

      // single lane, req dropped right after grant
      req = 2'b01; tap_ready = 1'b1;
      step(1); chk("t1_grant", grant, 2'b01);
      req = 2'b00;
      step(1); chk("t1_idx0", {tap_valid, 11'(tap_idx), tap_data}, {1'b1, 11'd0, 16'h3330});
      step(2); chk("t1_idx2", {11'(tap_idx), tap_data}, {11'd2, 16'h38F0});
      step(22); chk("t1_idx24", {tap_last, 11'(tap_idx), tap_data}, {1'b1, 11'd24, 16'h3980});
      step(1); chk("t1_done", done, 1'b1);
      step(1); chk("t1_busy_low", {busy, done}, 2'b00);

      // contention and round-robin fairness
      do_reset();
      req = 2'b11;
      step(1); chk("fair_first", {grant, tap_lane}, {2'b01, 1'b0});
      for (int i = 1; i < 4; i++) begin
         wait_done();
         step(2); chk("fair_grant", grant, fair_exp[i]);
      end
      req = 2'b00;
      wait_done();
      step(2);

      // backpressure on idx 6
      req = 2'b01; tap_ready = 1'b1;
      step(1); g_cyc = cyc; req = 2'b00;
      wait_idx(6);
      tap_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1); chk("bp_hold", {11'(tap_idx), tap_data}, {11'd6, 16'h38F0});
      end
      tap_ready = 1'b1;
      step(1); chk("bp_next", {11'(tap_idx), tap_data}, {11'd7, 16'h35C0});
      wait_done();
      chk("bp_length", cyc - g_cyc, 29);
      step(2);

      // reset mid-burst, then restart on lane 1
      req = 2'b10;
      wait_idx(12);
      rst = 1'b1;
      step(1);
      chk("mid_rst", {grant, busy, done, tap_valid, tap_last}, 6'b0);
      rst = 1'b0;
      step(1); chk("mid_regrant", grant, 2'b10);
      step(1); chk("mid_idx0", {tap_lane, 11'(tap_idx)}, {1'b1, 11'd0});
      req = 2'b00;
      wait_done();
      step(2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         req = 2'($urandom_range(0, 3));
         tap_ready = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 399) == 0);
         step(1);
      end
      rst = 1'b0; req = 2'b00;
      step(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
